// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end: FSM encoding,
// frame constants and the half-bit counter helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Last counter value of the half-bit wait used to reach mid start bit.
    function automatic int half_bit_last(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive buffer with full/empty tracking and sticky overrun.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, wdata       byte from the receiver FSM
//   pop_ready         consumer ready; pop when valid && pop_ready
//   err_clr           synchronous clear of overrun (a new overrun wins)
//   rdata, valid      head entry (0 when empty), FIFO not empty
//   overrun           sticky: push dropped because the FIFO was full
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 valid,
    output logic                 overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]          wptr_q, wptr_d;
    logic [AW:0]          rptr_q, rptr_d;
    logic                 overrun_q, overrun_d;
    logic                 empty, full;
    logic                 do_pop, do_push, ovf;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop_ready && !empty;
        // A pop in the same cycle frees the slot the push lands in.
        do_push = push && (!full || do_pop);
        ovf     = push && full && !do_pop;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
        overrun_d = (overrun_q && !err_clr) || ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid   = !empty;
    assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchroniser, 8N1 receiver FSM and a
// show-ahead FIFO drained over a valid/ready handshake.
// Optional build macro UART_RX_PARITY_EN: 8E1 frame, adds parity_err.
// Ports:
//   clock_50_b7a, reset   clock, async active-low reset
//   uart_rx               raw serial pin, idle high
//   rx_data, rx_valid     FIFO head byte and not-empty flag
//   rx_ready              consumer pops on rx_valid && rx_ready
//   frame_err, overrun    sticky error flags, cleared by err_clr
//   parity_err            sticky parity error (parity build only)
//   busy                  receiver FSM not idle
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock_50_b7a,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST =
        CW'(half_bit_last(CLKS_PER_BIT));
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rxs;
    logic                 push;
    logic                 frame_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
    logic                 parity_set;
`endif

    assign rxs = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], uart_rx};
        state_d   = state_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        parity_set = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (rxs != IDLE_LEVEL) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d  = '0;
                    bidx_d = '0;
                    // High at mid start bit is a glitch, not a frame.
                    state_d = (rxs == IDLE_LEVEL) ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d           = '0;
                    shift_d[bidx_q] = rxs;
                    if (bidx_q == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bidx_d = bidx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // Leave at mid stop bit so a back-to-back start
                    // edge is not missed.
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    parity_set = ^{shift_q, par_q};
                    if (rxs == IDLE_LEVEL) begin
                        push = !parity_set;
                    end else begin
                        frame_set = 1'b1;
                    end
`else
                    if (rxs == IDLE_LEVEL) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        frame_err_d = (frame_err_q && !err_clr) || frame_set;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q && !err_clr) || parity_set;
`endif
    end

    always_ff @(posedge clock_50_b7a or negedge reset) begin
        if (!reset) begin
            sync_q      <= {2{IDLE_LEVEL}};
            state_q     <= IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock_50_b7a),
        .rst_n     (reset),
        .push      (push),
        .wdata     (shift_q),
        .pop_ready (rx_ready),
        .err_clr   (err_clr),
        .rdata     (rx_data),
        .valid     (rx_valid),
        .overrun   (overrun)
    );

    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
